// File: rtl/quant_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quant_seq_ctrl_pkg
//  Description : Shared constants and state encoding for the bias-load /
//                convolution / quantize sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package quant_seq_ctrl_pkg;

    localparam int C_PARAM_WIDTH = 4;    // bits per packed parameter
    localparam int C_PARAM_NUM   = 9;    // parameters per param-SRAM word
    localparam int C_CH_NUM      = 20;   // output channels (= biases) per layer
    localparam int C_PIPE_FILL   = 6;    // conv pipeline fill cycles
    localparam int C_ADDR_W      = 10;   // param SRAM address width
    localparam int C_PIX_W       = 10;   // pixel counter width
    localparam int C_CNT_W       = 6;    // bias / channel counter width

    // Bias phase length and the three param-SRAM read slots within it
    localparam int C_BIAS_LAST   = 22;
    localparam int C_BIAS_RD0    = 1;
    localparam int C_BIAS_RD1    = 10;
    localparam int C_BIAS_RD2    = 19;

    // Phase codes decoded by the quantizer
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_C11_BIAS = 4'd3,
        ST_C11      = 4'd4,
        ST_C12_BIAS = 4'd5,
        ST_C12      = 4'd6,
        ST_DONE     = 4'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/quant_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : quant_seq_ctrl_if
//  Description : Control / quantizer / param-SRAM bundle of the sequencer.
//                master = top-level controller side, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface quant_seq_ctrl_if;
    import quant_seq_ctrl_pkg::*;

    logic                start;
    logic                layer_sel;
    logic [C_ADDR_W-1:0] bias_base;
    logic [C_PIX_W-1:0]  pix_num;
    logic                out_ready;
    logic [3:0]          state;
    logic                sram_ren_param;
    logic [C_ADDR_W-1:0] sram_raddr_param;
    logic [C_CNT_W-1:0]  cnt_bias;
    logic [C_CNT_W-1:0]  cnt_ch;
    logic [C_PIX_W-1:0]  cnt_pix;
    logic                out_valid;
    logic                done;

    modport master (
        output start, layer_sel, bias_base, pix_num, out_ready,
        input  state, sram_ren_param, sram_raddr_param, cnt_bias,
               cnt_ch, cnt_pix, out_valid, done
    );

    modport slave (
        input  start, layer_sel, bias_base, pix_num, out_ready,
        output state, sram_ren_param, sram_raddr_param, cnt_bias,
               cnt_ch, cnt_pix, out_valid, done
    );

endinterface
`default_nettype wire

// File: rtl/quant_seq_ctrl_bias_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : quant_bias_fetch
//  Description : Bias-phase counter and param-SRAM read schedule. Issues one
//                read of each of the three bias words and flags the final
//                bias-phase cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module quant_bias_fetch
    import quant_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_active,
    input  logic [C_ADDR_W-1:0] i_bias_base,
    output logic [C_CNT_W-1:0]  o_cnt_bias,
    output logic                o_sram_ren,
    output logic [C_ADDR_W-1:0] o_sram_raddr,
    output logic                o_bias_last
);

    // Reads are registered, so each slot is armed one count earlier
    localparam logic [C_CNT_W-1:0] c_rd0  = C_CNT_W'(C_BIAS_RD0 - 1);
    localparam logic [C_CNT_W-1:0] c_rd1  = C_CNT_W'(C_BIAS_RD1 - 1);
    localparam logic [C_CNT_W-1:0] c_rd2  = C_CNT_W'(C_BIAS_RD2 - 1);
    localparam logic [C_CNT_W-1:0] c_last = C_CNT_W'(C_BIAS_LAST);

    logic [C_CNT_W-1:0]  r_cnt_bias;
    logic                r_ren;
    logic [C_ADDR_W-1:0] r_raddr;

    // Free-running bias counter with single-cycle read strobes; address holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_bias <= '0;
            r_ren      <= 1'b0;
            r_raddr    <= '0;
        end else if (i_active) begin
            r_cnt_bias <= (r_cnt_bias == c_last) ? '0 : r_cnt_bias + 1'b1;
            r_ren      <= 1'b0;
            if (r_cnt_bias == c_rd0) begin
                r_ren   <= 1'b1;
                r_raddr <= i_bias_base;
            end else if (r_cnt_bias == c_rd1) begin
                r_ren   <= 1'b1;
                r_raddr <= i_bias_base + C_ADDR_W'(1);
            end else if (r_cnt_bias == c_rd2) begin
                r_ren   <= 1'b1;
                r_raddr <= i_bias_base + C_ADDR_W'(2);
            end
        end else begin
            r_cnt_bias <= '0;
            r_ren      <= 1'b0;
        end
    end

    assign o_cnt_bias   = r_cnt_bias;
    assign o_sram_ren   = r_ren;
    assign o_sram_raddr = r_raddr;
    assign o_bias_last  = i_active && (r_cnt_bias == c_last);

endmodule
`default_nettype wire

// File: rtl/quant_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : quant_seq_ctrl
//  Description : Per-layer sequencer: bias fetch, then channel/pixel walk
//                with downstream back-pressure, then a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module quant_seq_ctrl
    import quant_seq_ctrl_pkg::*;
#(
    parameter int PIPE_FILL = C_PIPE_FILL,
    parameter int CH_NUM    = C_CH_NUM
)(
    input  logic            clk,
    input  logic            rst_n,
    quant_seq_ctrl_if.slave bus
);

    state_t              r_state;
    logic                r_layer;
    logic [C_ADDR_W-1:0] r_bias_base;
    logic [C_PIX_W-1:0]  r_pix_last;
    logic [C_CNT_W-1:0]  r_cnt_ch;
    logic [C_PIX_W-1:0]  r_cnt_pix;
    logic                r_out_valid;
    logic                r_done;

    logic                w_bias_active;
    logic                w_bias_last;
    logic [C_CNT_W-1:0]  w_cnt_bias;
    logic                w_ren;
    logic [C_ADDR_W-1:0] w_raddr;
    logic                w_stall;
    logic                w_pix_wrap;
    logic                w_ch_last;
    logic [C_PIX_W-1:0]  w_pix_next;

    assign w_bias_active = (r_state == ST_C11_BIAS) || (r_state == ST_C12_BIAS);
    // Only a valid pixel can be refused; fill cycles always advance
    assign w_stall       = r_out_valid && !bus.out_ready;
    assign w_pix_wrap    = (r_cnt_pix == r_pix_last);
    assign w_ch_last     = (r_cnt_ch == C_CNT_W'(CH_NUM - 1));
    assign w_pix_next    = w_pix_wrap ? '0 : r_cnt_pix + 1'b1;

    quant_bias_fetch u_bias_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_active     (w_bias_active),
        .i_bias_base  (r_bias_base),
        .o_cnt_bias   (w_cnt_bias),
        .o_sram_ren   (w_ren),
        .o_sram_raddr (w_raddr),
        .o_bias_last  (w_bias_last)
    );

    // Layer FSM with channel/pixel counters and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_layer     <= 1'b0;
            r_bias_base <= '0;
            r_pix_last  <= '0;
            r_cnt_ch    <= '0;
            r_cnt_pix   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_layer     <= bus.layer_sel;
                        r_bias_base <= bus.bias_base;
                        r_pix_last  <= bus.pix_num + C_PIX_W'(PIPE_FILL - 1);
                        r_state     <= bus.layer_sel ? ST_C12_BIAS : ST_C11_BIAS;
                    end
                end
                ST_C11_BIAS, ST_C12_BIAS: begin
                    if (w_bias_last) begin
                        r_state     <= r_layer ? ST_C12 : ST_C11;
                        r_cnt_ch    <= '0;
                        r_cnt_pix   <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_C11, ST_C12: begin
                    if (!w_stall) begin
                        if (w_pix_wrap && w_ch_last) begin
                            r_state     <= ST_DONE;
                            r_cnt_ch    <= '0;
                            r_cnt_pix   <= '0;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            if (w_pix_wrap) begin
                                r_cnt_ch <= r_cnt_ch + 1'b1;
                            end
                            r_cnt_pix   <= w_pix_next;
                            r_out_valid <= (w_pix_next >= C_PIX_W'(PIPE_FILL));
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt_ch    <= '0;
                    r_cnt_pix   <= '0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state            = r_state;
    assign bus.sram_ren_param   = w_ren;
    assign bus.sram_raddr_param = w_raddr;
    assign bus.cnt_bias         = w_cnt_bias;
    assign bus.cnt_ch           = r_cnt_ch;
    assign bus.cnt_pix          = r_cnt_pix;
    assign bus.out_valid        = r_out_valid;
    assign bus.done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_quant_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quant_seq_ctrl
//  Description : Directed bench for quant_seq_ctrl. Each layer run builds its
//                expected per-cycle output trace into a scoreboard queue; the
//                trace also carries the out_ready/start values to drive.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_quant_seq_ctrl;
    import quant_seq_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quant_seq_ctrl_if bus ();

    quant_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ren;
        logic [9:0] addr;
        logic [5:0] cb;
        logic [5:0] ch;
        logic [9:0] pix;
        logic       ov;
        logic       dn;
    } vec_t;

    typedef struct {
        vec_t v;
        logic rdy;
        logic start;
    } ent_t;

    ent_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] last_addr = '0;

    function automatic vec_t observe();
        vec_t v;
        v.st   = bus.state;
        v.ren  = bus.sram_ren_param;
        v.addr = bus.sram_raddr_param;
        v.cb   = bus.cnt_bias;
        v.ch   = bus.cnt_ch;
        v.pix  = bus.cnt_pix;
        v.ov   = bus.out_valid;
        v.dn   = bus.done;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t obs, input vec_t exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input vec_t v, input logic rdy, input logic st);
        ent_t e;
        e.v = v;
        e.rdy = rdy;
        e.start = st;
        sb.push_back(e);
    endtask

    // Expected trace from the first bias cycle through two idle cycles after done
    task automatic build_layer(input logic layer, input logic [9:0] base, input int pixn,
                               input int stall_ch, input int stall_pix, input int stall_len,
                               input int start_ch, input logic start_in_done);
        vec_t       v;
        logic [9:0] a;
        a = last_addr;
        for (int k = 0; k <= 22; k++) begin
            if (k == 1)  a = base;
            if (k == 10) a = base + 10'd1;
            if (k == 19) a = base + 10'd2;
            v = '0;
            v.st   = layer ? 4'd5 : 4'd3;
            v.cb   = 6'(k);
            v.ren  = (k == 1) || (k == 10) || (k == 19);
            v.addr = a;
            push(v, 1'b1, 1'b0);
        end
        for (int ch = 0; ch < 20; ch++) begin
            for (int pix = 0; pix < pixn + 6; pix++) begin
                v = '0;
                v.st   = layer ? 4'd6 : 4'd4;
                v.addr = a;
                v.ch   = 6'(ch);
                v.pix  = 10'(pix);
                v.ov   = (pix >= 6);
                if (ch == stall_ch && pix == stall_pix)
                    for (int s = 0; s < stall_len; s++) push(v, 1'b0, 1'b0);
                // ready is withheld throughout fill: those cycles must advance anyway
                push(v, (pix >= 6), (ch == start_ch) && (pix == 0));
            end
        end
        v = '0;
        v.st   = 4'd7;
        v.addr = a;
        v.dn   = 1'b1;
        push(v, 1'b1, start_in_done);
        v = '0;
        v.addr = a;
        push(v, 1'b1, 1'b0);
        push(v, 1'b1, 1'b0);
        last_addr = a;
    endtask

    task automatic run_layer(input string name, input logic layer, input logic [9:0] base,
                             input int pixn, input int stall_ch, input int stall_pix,
                             input int stall_len, input int start_ch,
                             input logic start_in_done, input int abort_ch);
        ent_t e;
        int   idx;
        build_layer(layer, base, pixn, stall_ch, stall_pix, stall_len, start_ch, start_in_done);
        bus.layer_sel = layer;
        bus.bias_base = base;
        bus.pix_num   = 10'(pixn);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s_c%0d", name, idx), observe(), e.v);
            bus.out_ready = e.rdy;
            bus.start     = e.start;
            if (abort_ch >= 0 && e.v.ch == 6'(abort_ch) && e.v.pix == 10'd0 &&
                (e.v.st == 4'd4 || e.v.st == 4'd6)) begin
                rst_n = 1'b0;
                #1;
                check({name, "_async_rst"}, observe(), '0);
                sb.delete();
                last_addr = '0;
                bus.start = 1'b0;
                @(posedge clk); #1;
                check({name, "_rst_hold"}, observe(), '0);
                rst_n = 1'b1;
                break;
            end
            idx++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.layer_sel = 1'b0;
        bus.bias_base = '0;
        bus.pix_num   = '0;
        bus.out_ready = 1'b0;

        // Reset held, then idle with no start
        repeat (3) @(posedge clk);
        #1;
        check("reset", observe(), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_%0d", i), observe(), '0);
        end

        run_layer("conv11",   1'b0, 10'd40,  4, -1, 0, 0, -1, 1'b0, -1);
        run_layer("conv12",   1'b1, 10'd40,  4, -1, 0, 0, -1, 1'b0, -1);
        run_layer("stall",    1'b0, 10'd40,  4,  2, 7, 3, -1, 1'b0, -1);
        run_layer("abort",    1'b1, 10'd100, 4, -1, 0, 0, -1, 1'b0,  5);
        run_layer("post_rst", 1'b0, 10'd40,  4, -1, 0, 0, -1, 1'b0, -1);
        run_layer("ign_start",1'b0, 10'd40,  4, -1, 0, 0,  3, 1'b1, -1);
        run_layer("pix1_wrap",1'b1, 10'd1022, 1, -1, 0, 0, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
